// File: rtl/sextium_io_port.sv
// Synthesizable I/O peripheral for the sextium_core I/O bus: RX/TX stream FIFOs behind an ioack handshake.
// Optional read timeout on an empty RX FIFO is compiled in with `define IO_READ_TIMEOUT_EN.

module sextium_io_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_q, level_d;
    logic                push_ok;
    logic                pop_ok;

    // The extra pointer bit separates "full" from "empty" when the low bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign level_o = level_q;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

module sextium_io_port #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [WIDTH-1:0]      io_bus_in,
    output logic [WIDTH-1:0]      io_bus_out,
    output logic                  ioack,
    input  logic                  rx_valid,
    input  logic [WIDTH-1:0]      rx_data,
    output logic                  rx_ready,
    output logic                  tx_valid,
    output logic [WIDTH-1:0]      tx_data,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic [DEPTH_LOG2:0]   tx_level
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RELEASE
    } state_t;

    if (DEPTH_LOG2 < 1 || TIMEOUT < 1) begin : g_param_check
        $error("sextium_io_port: DEPTH_LOG2 and TIMEOUT must be at least 1");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bus_out_q, bus_out_d;
    logic               rx_pop;
    logic               tx_push;
    logic [WIDTH-1:0]   rx_head;
    logic               rx_full, rx_empty;
    logic               tx_full, tx_empty;

    sextium_io_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_valid && rx_ready),
        .data_i  (rx_data),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .level_o (rx_level),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    sextium_io_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (tx_push),
        .data_i  (io_bus_in),
        .pop_i   (tx_valid && tx_ready),
        .head_o  (tx_data),
        .level_o (tx_level),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign rx_ready   = !rx_full;
    assign tx_valid   = !tx_empty;
    assign ioack      = (state_q == ST_ACK);
    assign io_bus_out = bus_out_q;

`ifdef IO_READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Read wins over write; RELEASE waits for both requests low so a held request is served once.
    always_comb begin
        state_d   = state_q;
        bus_out_d = bus_out_q;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
`ifdef IO_READ_TIMEOUT_EN
        cnt_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (io_read) begin
                    if (!rx_empty) begin
                        rx_pop    = 1'b1;
                        bus_out_d = rx_head;
                        state_d   = ST_ACK;
                    end
`ifdef IO_READ_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        bus_out_d = '0;
                        state_d   = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else if (io_write && !tx_full) begin
                    tx_push = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!io_read && !io_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bus_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bus_out_q <= bus_out_d;
        end
    end
endmodule

// File: tb/tb_sextium_io_port.sv
// Scoreboard bench for sextium_io_port: queue-based FIFO model, randomized core and stream traffic.
// With IO_READ_TIMEOUT_EN defined the DUT is built with TIMEOUT=8 and the timeout read is exercised.

module tb_sextium_io_port;
    localparam int W  = 16;
    localparam int DL = 4;
    localparam int DEPTH = 16;
`ifdef IO_READ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_read = 1'b0;
    logic          io_write = 1'b0;
    logic [W-1:0]  io_bus_in = '0;
    logic [W-1:0]  io_bus_out;
    logic          ioack;
    logic          rx_valid = 1'b0;
    logic [W-1:0]  rx_data = '0;
    logic          rx_ready;
    logic          tx_valid;
    logic [W-1:0]  tx_data;
    logic          tx_ready = 1'b0;
    logic [DL:0]   rx_level;
    logic [DL:0]   tx_level;

    sextium_io_port #(.WIDTH(W), .DEPTH_LOG2(DL), .TIMEOUT(TB_TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_bus_in  (io_bus_in),
        .io_bus_out (io_bus_out),
        .ioack      (ioack),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_level   (rx_level),
        .tx_level   (tx_level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Scoreboard state: words accepted on RX not yet read, words written by the core not yet sent.
    logic [W-1:0] rx_exp[$];
    logic [W-1:0] tx_exp[$];
    int           op_issued = 0;
    int           ack_count = 0;
    bit           op_is_read = 1'b0;
    logic [W-1:0] op_wdata = '0;
    bit           ack_prev = 1'b0;
    bit           rand_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ioack completes the one outstanding core request.
    always @(negedge clock) begin
        if (!reset) begin
            rx_exp.delete();
            tx_exp.delete();
            ack_prev = 1'b0;
        end else begin
            if (ioack) begin
                chk("ack_single_cycle", {31'd0, ack_prev}, 32'd0);
                chk("ack_has_request", {31'd0, (ack_count < op_issued)}, 32'd1);
                if (ack_count < op_issued) begin
                    if (op_is_read) begin
                        if (rx_exp.size() > 0) begin
                            chk("read_data", {16'd0, io_bus_out}, {16'd0, rx_exp.pop_front()});
                        end else begin
`ifdef IO_READ_TIMEOUT_EN
                            chk("timeout_read_data", {16'd0, io_bus_out}, 32'd0);
`else
                            chk("read_from_empty", 32'd1, 32'd0);
`endif
                        end
                    end else begin
                        tx_exp.push_back(op_wdata);
                    end
                    ack_count++;
                end
                $display("ACK %s data=%04h rx_level=%0d tx_level=%0d", op_is_read ? "RD" : "WR",
                         op_is_read ? io_bus_out : op_wdata, rx_level, tx_level);
            end
            ack_prev = ioack;
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() > 0) begin
                    chk("tx_data", {16'd0, tx_data}, {16'd0, tx_exp.pop_front()});
                end else begin
                    chk("tx_pop_unexpected", 32'd1, 32'd0);
                end
                $display("TX  data=%04h", tx_data);
            end
            if (rx_valid && rx_ready) begin
                rx_exp.push_back(rx_data);
                $display("RX  data=%04h", rx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic core_issue(input bit is_read, input logic [W-1:0] wd);
        op_is_read = is_read;
        op_wdata   = wd;
        op_issued++;
        io_read    = is_read;
        io_write   = !is_read;
        io_bus_in  = wd;
    endtask

    task automatic core_finish(input int hold);
        int n = 0;
        while (ack_count < op_issued && n < 400) begin
            tick();
            n++;
        end
        chk("ack_within_bound", {31'd0, (ack_count >= op_issued)}, 32'd1);
        repeat (hold) tick();
        io_read  = 1'b0;
        io_write = 1'b0;
        tick();
    endtask

    task automatic core_op(input bit is_read, input logic [W-1:0] wd, input int hold);
        tick();
        core_issue(is_read, wd);
        core_finish(hold);
    endtask

    task automatic rx_push(input logic [W-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_idle_levels(input string tag);
        chk({tag, "_rx_level"}, {27'd0, rx_level}, rx_exp.size());
        chk({tag, "_tx_level"}, {27'd0, tx_level}, tx_exp.size());
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, (rx_exp.size() < DEPTH)});
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, {31'd0, (tx_exp.size() > 0)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #1;
        chk("rst_ioack", {31'd0, ioack}, 32'd0);
        chk("rst_bus_out", {16'd0, io_bus_out}, 32'd0);
        chk("rst_rx_level", {27'd0, rx_level}, 32'd0);
        chk("rst_tx_level", {27'd0, tx_level}, 32'd0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        tick();
        chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);

        // Two words in, two reads out in order, level walking down.
        rx_push(16'h1234);
        rx_push(16'hBEEF);
        chk("t1_rx_level2", {27'd0, rx_level}, 32'd2);
        core_op(1'b1, '0, 0);
        chk("t1_rx_level1", {27'd0, rx_level}, 32'd1);
        core_op(1'b1, '0, 0);
        chk("t1_rx_level0", {27'd0, rx_level}, 32'd0);

        // Fill TX, stall the 17th write, free one slot.
        tx_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) core_op(1'b0, W'(i), 0);
        chk("t2_tx_level_full", {27'd0, tx_level}, 32'd16);
        chk("t2_rx_ready_tx_full", {31'd0, tx_valid}, 32'd1);
        chk("t2_tx_head", {16'd0, tx_data}, 32'h0001);
        tick();
        core_issue(1'b0, 16'h0011);
        repeat (5) tick();
        chk("t2_write_stalled", ack_count, op_issued - 1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        core_finish(0);
        chk("t2_tx_level_after", {27'd0, tx_level}, 32'd16);
        tx_ready = 1'b1;
        repeat (20) tick();
        tx_ready = 1'b0;
        check_idle_levels("t2_drained");

        // Read stalls on empty RX; ack arrives two edges after the push edge.
        tick();
        core_issue(1'b1, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_no_ack", {31'd0, ioack}, 32'd0);
        end
        rx_valid = 1'b1;
        rx_data  = 16'h00AA;
        tick();
        rx_valid = 1'b0;
        chk("t3_ack_not_early", {31'd0, ioack}, 32'd0);
        tick();
        chk("t3_ack_latency", {31'd0, ioack}, 32'd1);
        chk("t3_bus_out", {16'd0, io_bus_out}, 32'h00AA);
        core_finish(0);

        // Held read after ack is not serviced again.
        rx_push(16'h5555);
        rx_push(16'h6666);
        tick();
        core_issue(1'b1, '0);
        begin
            int n = 0;
            while (ack_count < op_issued && n < 50) begin
                tick();
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_rx_level", {27'd0, rx_level}, 32'd1);
        end
        core_finish(0);
        core_op(1'b1, '0, 0);
        check_idle_levels("t4_done");

        // Reset while in ACK with three words left in RX.
        for (int i = 0; i < 4; i++) rx_push(W'(16'h0100 + i));
        tick();
        core_issue(1'b1, '0);
        begin
            int n = 0;
            while (!ioack && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t5_in_ack", {31'd0, ioack}, 32'd1);
        chk("t5_rx_level3", {27'd0, rx_level}, 32'd3);
        #1 reset = 1'b0;
        io_read = 1'b0;
        #1;
        chk("t5_rst_ioack", {31'd0, ioack}, 32'd0);
        chk("t5_rst_rx_level", {27'd0, rx_level}, 32'd0);
        chk("t5_rst_tx_level", {27'd0, tx_level}, 32'd0);
        op_issued = ack_count;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();
        chk("t5_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("t5_tx_valid", {31'd0, tx_valid}, 32'd0);

`ifdef IO_READ_TIMEOUT_EN
        // Timeout read on empty RX: ack after TIMEOUT stall cycles, no pop.
        core_issue(1'b1, '0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        chk("t6_no_ack_before_timeout", {31'd0, ioack}, 32'd0);
        tick();
        chk("t6_ack_at_timeout", {31'd0, ioack}, 32'd1);
        chk("t6_bus_out_zero", {16'd0, io_bus_out}, 32'd0);
        chk("t6_rx_level", {27'd0, rx_level}, 32'd0);
        core_finish(0);
`endif

        // Randomized mix of core traffic against free-running stream source and sink.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    bit           rd = 1'($urandom_range(0, 1));
                    logic [W-1:0] wd = W'($urandom);
`ifdef IO_READ_TIMEOUT_EN
                    if (rx_exp.size() == 0) rd = 1'b0;
`endif
                    core_op(rd, wd, $urandom_range(0, 3));
                end
                rand_done = 1'b1;
            end
            begin
                bit taken;
                while (!rand_done) begin
                    @(negedge clock);
                    taken = rx_valid && rx_ready;
                    tick();
                    if (taken || !rx_valid) begin
                        rx_valid = 1'($urandom_range(0, 1));
                        rx_data  = W'($urandom);
                    end
                    tx_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
                end
                rx_valid = 1'b0;
                tx_ready = 1'b0;
            end
        join
        repeat (3) tick();
        check_idle_levels("rand_end");
        tx_ready = 1'b1;
        repeat (24) tick();
        tx_ready = 1'b0;
        check_idle_levels("rand_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sextium_io_port.md
Name: sextium_io_port

Overview:
Synthesizable I/O peripheral on the sextium_core I/O bus, in the position the simulation-only I/O model occupies in the testbench. It answers core io_read/io_write requests with an ioack handshake. An RX FIFO buffers words arriving from an external stream source, and a TX FIFO buffers words the core writes for an external stream sink. The external side uses valid/ready streams, so a UART or host bridge attaches directly.

Parameters:
WIDTH, 16, word width of the I/O bus and both FIFOs
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries)
TIMEOUT, 1024, read-timeout cycle count; used only with IO_READ_TIMEOUT_EN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
io_read  in  1  core read request, level, held until ioack
io_write  in  1  core write request, level, held until ioack
io_bus_in  in  WIDTH  write data from core, valid while io_write
io_bus_out  out  WIDTH  read data to core, valid in the ioack cycle of a read
ioack  out  1  one-cycle transfer-complete pulse
rx_valid  in  1  external word available
rx_data  in  WIDTH  external word
rx_ready  out  1  RX FIFO can accept; push when rx_valid&&rx_ready
tx_valid  out  1  TX FIFO non-empty
tx_data  out  WIDTH  TX FIFO head word
tx_ready  in  1  sink accepts; pop when tx_valid&&tx_ready
rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy
tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs empty, pointers 0, levels 0, ioack=0, io_bus_out=0, FSM=IDLE. rx_ready=1 and tx_valid=0 while not in reset.
- FIFOs: circular, 2^DEPTH_LOG2 entries. Pointers carry one extra wrap bit. Full when level=2^DEPTH_LOG2, empty when level=0.
- rx_ready=!rx_full. tx_valid=!tx_empty. tx_data=head. All three are combinational from FIFO state.
- A simultaneous push and pop on a FIFO in one edge: both occur and the level is unchanged.
- FSM states: IDLE, ACK, RELEASE.
- IDLE, io_read=1, RX non-empty:
  - Pop RX.
  - Register the head word into io_bus_out.
  - Go to ACK with ioack=1 on the next cycle (latency 1).
- IDLE, io_read=1, RX empty: stay in IDLE, no ack (stall). Service starts at the first edge at which RX is non-empty, including a word pushed that same edge, which becomes visible next cycle.
- IDLE, io_write=1 (io_read=0), TX not full:
  - Push io_bus_in into TX.
  - Go to ACK with ioack=1 next cycle.
- IDLE, io_write=1, TX full: stall. Service when a tx pop frees a slot.
- io_read and io_write both 1: read has priority and the write is ignored.
- ACK: ioack=1 for exactly this cycle, then go to RELEASE. io_bus_out holds its value until the next read.
- RELEASE: ioack=0. Return to IDLE when io_read=0 and io_write=0. A request held high across ack is never serviced twice.
- Reset mid-transfer: the FSM aborts to IDLE and FIFO contents are discarded. A request still high after reset release is serviced as new.
- rx_level and tx_level are registered counts, updated on the same edge as the push/pop.

Optional Feature:
IO_READ_TIMEOUT_EN:
- Defined: a cycle counter runs while in IDLE with io_read=1 and RX empty. When it reaches TIMEOUT, go to ACK with io_bus_out=0 and do not pop. The counter clears on any ack or on request drop.
- Undefined: a read on an empty RX stalls indefinitely and no counter logic exists.

Test Plan:
1. Push 0x1234 and 0xBEEF on rx, then two core reads → ioack pulses one cycle each; io_bus_out = 0x1234 then 0xBEEF; rx_level 2→1→0.
2. Core writes 0x0001..0x0010 (16 words) with tx_ready=0, then a 17th write of 0x0011 → first 16 acked, 17th stalls. Raise tx_ready for one cycle → tx_data=0x0001 popped, 17th acked next cycle, tx_level=16.
3. Core read with RX empty, push 0x00AA five cycles later → ioack occurs exactly 2 cycles after the push edge; io_bus_out=0xAA.
4. Hold io_read high 10 cycles after ack with RX containing 0x5555 → no second ack and rx_level unchanged until io_read drops.
5. Assert reset=0 while in ACK with rx_level=3 → ioack=0 immediately, levels 0, rx_ready=1 after release.
6. IO_READ_TIMEOUT_EN defined, TIMEOUT=8, read with RX empty → ioack with io_bus_out=0x0000 after 8 stall cycles; rx_level stays 0.
